// File: rtl/m_ucodeseq.sv
// Microcode sequencer: produces the microcode store index and its advance qualifier.
// It steps, dispatches, redirects to the trap entry, holds on bus waits and freezes during shifts.
module m_ucodeseq #(
   parameter logic [7:0] RESET_ENTRY = 8'h00,
   parameter logic [7:0] TRAP_ENTRY  = 8'hF0,
   parameter int unsigned SHCNT_W    = 5
) (
   input  logic               clk,
   input  logic               RST_I,
   input  logic               dispatch,
   input  logic [7:0]         entry_index,
   input  logic               bus_wait,
   input  logic               start_shift,
   input  logic [SHCNT_W-1:0] shamt,
   input  logic               irq_pending,
   output logic [7:0]         minx,
   output logic               progress_ucode,
   output logic               shift_busy,
   output logic               instret_pulse,
   output logic               trap_taken
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_SHIFT = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   localparam logic [SHCNT_W-1:0] CNT_ONE = SHCNT_W'(1);

   state_t             state_q, state_d;
   logic [7:0]         minx_q, minx_d;
   logic [SHCNT_W-1:0] cnt_q, cnt_d;
   logic               progress_q;
   logic               busy_q;
   logic               instret_q, instret_d;
   logic               trap_q, trap_d;

   always_comb begin
      state_d   = state_q;
      minx_d    = minx_q;
      cnt_d     = cnt_q;
      instret_d = 1'b0;
      trap_d    = 1'b0;
      case (state_q)
         S_SHIFT: begin
            if (cnt_q == CNT_ONE) begin
               state_d = S_RUN;
               minx_d  = minx_q + 8'd1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            // WAIT shares the RUN rules: leaving WAIT applies them to the inputs on the same edge.
            if (bus_wait) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_RUN;
               if (start_shift) begin
                  if (shamt != '0) begin
                     state_d = S_SHIFT;
                     cnt_d   = shamt;
                  end else begin
                     minx_d = minx_q + 8'd1;
                  end
               end else if (dispatch) begin
                  if (irq_pending) begin
                     minx_d = TRAP_ENTRY;
                     trap_d = 1'b1;
                  end else begin
                     minx_d    = entry_index;
                     instret_d = 1'b1;
                  end
               end else begin
                  minx_d = minx_q + 8'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge RST_I) begin
      if (RST_I) begin
         state_q    <= S_RUN;
         minx_q     <= RESET_ENTRY;
         cnt_q      <= '0;
         progress_q <= 1'b1;
         busy_q     <= 1'b0;
         instret_q  <= 1'b0;
         trap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         minx_q     <= minx_d;
         cnt_q      <= cnt_d;
         progress_q <= (state_d == S_RUN);
         busy_q     <= (state_d == S_SHIFT);
         instret_q  <= instret_d;
         trap_q     <= trap_d;
      end
   end

   assign minx           = minx_q;
   assign progress_ucode = progress_q;
   assign shift_busy     = busy_q;
   assign instret_pulse  = instret_q;
   assign trap_taken     = trap_q;

endmodule
